// File: rtl/count_chk_pkg.sv
// Shared state encodings, default widths and sizing helper for the counter sequence checker.
// Pure declarations: no latency, no flow control.
package count_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_LOSS_CNT = 3;
  localparam int DEF_ERR_W    = 16;

  // Run counters must hold the larger of the two thresholds.
  function automatic int run_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// One cycle from inc/clr to q; no backpressure, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Checks each enabled sample is previous+1 (mod 2^DATA_W), locks after a good run, counts errors.
// Outputs registered, one cycle after the sample edge; en low stalls all sequence state.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  output logic [1:0]        state,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [DATA_W-1:0] err_got,
  output logic [DATA_W-1:0] err_exp
);

  localparam int RW = run_w(LOCK_CNT, LOSS_CNT);

  state_t            st;
  logic [DATA_W-1:0] exp_q;
  logic [RW-1:0]     good_run;
  logic [RW-1:0]     bad_run;
  logic              match;
  logic              miss;
  logic [RW-1:0]     good_nxt;
  logic [RW-1:0]     bad_nxt;

  assign match    = (data_in == exp_q);
  assign miss     = en && (st == ST_LOCKED) && !match;
  assign good_nxt = good_run + RW'(1);
  assign bad_nxt  = bad_run + RW'(1);
  assign state    = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      exp_q     <= '0;
      good_run  <= '0;
      bad_run   <= '0;
    end else begin
      err_pulse <= miss;
      if (en) begin
        // Always resync to the sample so a single jump is reported only once.
        exp_q <= data_in + DATA_W'(1);
        unique case (st)
          ST_IDLE: begin
            good_run <= RW'(1);
            st       <= ST_SEARCH;
          end
          ST_SEARCH: begin
            if (!match) begin
              good_run <= RW'(1);
            end else if (good_nxt == RW'(LOCK_CNT)) begin
              st      <= ST_LOCKED;
              locked  <= 1'b1;
              bad_run <= '0;
            end else begin
              good_run <= good_nxt;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              bad_run <= '0;
            end else if (bad_nxt == RW'(LOSS_CNT)) begin
              st       <= ST_SEARCH;
              locked   <= 1'b0;
              good_run <= RW'(1);
              bad_run  <= '0;
            end else begin
              bad_run <= bad_nxt;
            end
          end
          default: begin
            st     <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_got <= '0;
      err_exp <= '0;
    end else if (clear) begin
      err_got <= '0;
      err_exp <= '0;
    end else if (miss) begin
      err_got <= data_in;
      err_exp <= exp_q;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(miss),
    .clr(clear),
    .q  (err_count)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed scenarios plus random traffic against a behavioural model; two DUTs (ERR_W 16 and 2).
module tb_count_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  data_in;
  logic        clear;

  logic [1:0]  state_a, state_b;
  logic        locked_a, locked_b, pulse_a, pulse_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [7:0]  got_a, got_b, exp_a, exp_b;

  always #5 clk = ~clk;

  count_seq_checker #(.DATA_W(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clear(clear),
    .state(state_a), .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a),
    .err_got(got_a), .err_exp(exp_a)
  );

  count_seq_checker #(.DATA_W(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clear(clear),
    .state(state_b), .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b),
    .err_got(got_b), .err_exp(exp_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_on  = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
  endtask

  // Behavioural model: mode 0 idle, 1 searching, 2 locked; expected next value as plain int.
  int m_mode = 0, m_next = 0, m_good = 0, m_bad = 0;
  int m_pulse = 0, m_got = 0, m_snap = 0;
  int m_cnt_a = 0, m_cnt_b = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_next = 0; m_good = 0; m_bad = 0;
      m_pulse = 0; m_got = 0; m_snap = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      int d;
      bit err;
      d = int'(data_in);
      err = 1'b0;
      m_pulse = 0;
      if (en) begin
        if (m_mode == 0) begin
          m_good = 1;
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (d == m_next) begin
            m_good++;
            if (m_good >= 4) begin m_mode = 2; m_bad = 0; end
          end else m_good = 1;
        end else begin
          if (d == m_next) m_bad = 0;
          else begin
            err = 1'b1;
            m_pulse = 1;
            m_bad++;
            if (m_bad >= 3) begin m_mode = 1; m_good = 1; m_bad = 0; end
          end
        end
      end
      if (clear) begin
        m_cnt_a = 0; m_cnt_b = 0; m_got = 0; m_snap = 0;
      end else if (err) begin
        m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
        m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
        m_got = d;
        m_snap = m_next;
      end
      if (en) m_next = (d + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("state_a", int'(state_a), m_mode);
      chk("state_b", int'(state_b), m_mode);
      chk("locked_a", int'(locked_a), (m_mode == 2) ? 1 : 0);
      chk("locked_b", int'(locked_b), (m_mode == 2) ? 1 : 0);
      chk("pulse_a", int'(pulse_a), m_pulse);
      chk("pulse_b", int'(pulse_b), m_pulse);
      chk("count_a", int'(cnt_a), m_cnt_a);
      chk("count_b", int'(cnt_b), m_cnt_b);
      chk("got_a", int'(got_a), m_got);
      chk("got_b", int'(got_b), m_got);
      chk("exp_a", int'(exp_a), m_snap);
      chk("exp_b", int'(exp_b), m_snap);
    end
  end

  task automatic drive(input logic e, input logic [7:0] d, input logic c);
    @(negedge clk);
    #1;
    en = e;
    data_in = d;
    clear = c;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] j;
    rst = 1'b1; en = 1'b0; data_in = '0; clear = 1'b0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_state", int'(state_a), 0);
    chk("rst_locked", int'(locked_a), 0);
    chk("rst_count", int'(cnt_a), 0);
    #1 rst = 1'b0;

    // 1: lock on 0,1,2,3
    drive(1, 8'd0, 0); settle();
    chk("t1_search", int'(state_a), 1);
    drive(1, 8'd1, 0); drive(1, 8'd2, 0); settle();
    chk("t1_not_yet", int'(locked_a), 0);
    drive(1, 8'd3, 0); settle();
    chk("t1_locked", int'(locked_a), 1);
    chk("t1_state", int'(state_a), 2);

    // 2: wrap through 255 -> 0 is legal
    for (int d = 4; d < 256; d++) drive(1, 8'(d), 0);
    drive(1, 8'd0, 0); drive(1, 8'd1, 0); settle();
    chk("t2_locked", int'(locked_a), 1);
    chk("t2_count", int'(cnt_a), 0);
    chk("t2_model_mode", m_mode, 2);

    // 3: single jump 11 -> 20
    for (int d = 2; d < 12; d++) drive(1, 8'(d), 0);
    drive(1, 8'd20, 0); settle();
    chk("t3_pulse", int'(pulse_a), 1);
    chk("t3_count", int'(cnt_a), 1);
    chk("t3_got", int'(got_a), 20);
    chk("t3_exp", int'(exp_a), 12);
    chk("t3_model_snap", m_snap, 12);
    drive(1, 8'd21, 0); drive(1, 8'd22, 0); settle();
    chk("t3_still_locked", int'(state_a), 2);
    chk("t3_pulse_low", int'(pulse_a), 0);

    // 4: three bad samples drop lock, three more good samples relock
    drive(0, 8'd0, 1);
    drive(1, 8'd5, 0); settle(); chk("t4_pulse1", int'(pulse_a), 1);
    drive(1, 8'd9, 0); settle(); chk("t4_pulse2", int'(pulse_a), 1);
    drive(1, 8'd40, 0); settle(); chk("t4_pulse3", int'(pulse_a), 1);
    chk("t4_count", int'(cnt_a), 3);
    chk("t4_search", int'(state_a), 1);
    chk("t4_got", int'(got_a), 40);
    for (int d = 41; d < 45; d++) drive(1, 8'(d), 0);
    settle();
    chk("t4_relocked", int'(locked_a), 1);

    // 5: en toggling with held data, then clear colliding with a mismatch
    drive(0, 8'd44, 1);
    cur = 8'd45;
    for (int i = 0; i < 6; i++) begin
      drive(1, cur, 0);
      drive(0, cur, 0);
      cur = cur + 8'd1;
    end
    settle();
    chk("t5_count", int'(cnt_a), 0);
    chk("t5_locked", int'(locked_a), 1);
    drive(1, cur + 8'd50, 1); settle();
    chk("t5_pulse", int'(pulse_a), 1);
    chk("t5_count_clr", int'(cnt_a), 0);
    chk("t5_got_clr", int'(got_a), 0);
    cur = cur + 8'd51;

    // 6: five isolated errors saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      j = cur + 8'd7;
      drive(1, j, 0); drive(1, j + 8'd1, 0); drive(1, j + 8'd2, 0);
      cur = j + 8'd3;
    end
    settle();
    chk("t6_sat_b", int'(cnt_b), 3);
    chk("t6_count_a", int'(cnt_a), 5);
    chk("t6_locked", int'(locked_a), 1);

    // rst mid-stream
    drive(1, cur, 0);
    @(negedge clk); #1 rst = 1'b1; #1;
    chk("t6_rst_state", int'(state_a), 0);
    chk("t6_rst_count", int'(cnt_a), 0);
    chk("t6_rst_got", int'(got_a), 0);
    chk("t6_rst_locked", int'(locked_b), 0);
    settle();
    chk("t6_rst_idle", int'(state_a), 0);
    @(negedge clk); #1 rst = 1'b0; en = 1'b0;
    drive(1, 8'd7, 0); settle();
    chk("t6_after_rst", int'(state_a), 1);

    // random traffic: mostly sequential, occasional jumps, stalls, clears and resets
    cur = 8'd8;
    for (int i = 0; i < 3000; i++) begin
      logic e, c;
      logic [7:0] d;
      e = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 3);
      d = ($urandom_range(0, 99) < 85) ? cur : 8'($urandom_range(0, 255));
      drive(e, d, c);
      if (e) cur = d + 8'd1;
      if ($urandom_range(0, 999) < 3) begin
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
      end
    end
    drive(0, 8'd0, 0);
    settle();
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
